ptw_dcache_port_arbiter: RTL

- Shares one data-cache load request port between NUM_REQ page-table-walker style requesters, e.g. the shared-TLB PTW and a future G-stage/prefetch walker.
- Sequences the split-phase cache protocol: index/request, grant, tag one cycle later, then response.
- Allows one outstanding transaction at a time and arbitrates round-robin between requesters.
- Routes the response back to the requester that issued it and kills or drops in-flight traffic on flush.

---
 rtl/ptw_dcache_port_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ptw_dcache_port_arbiter.sv
// Round-robin arbiter sharing one split-phase data-cache load port between page-table walkers.
// Optional RESP watchdog enabled by defining PTW_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; pick the next requester round-robin
// REQ   | dc_req_o high for the owner, waiting for dc_gnt_i
// TAG   | one-cycle tag phase; kill issued here if flushed
// RESP  | waiting for the response whose rid matches the owner's id
module ptw_dcache_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 12,
    parameter int TAG_W   = 44,
    parameter int DATA_W  = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*IDX_W-1:0]  index_i,
    input  logic [NUM_REQ*TAG_W-1:0]  tag_i,
    input  logic [NUM_REQ*8-1:0]      be_i,
    input  logic [NUM_REQ*2-1:0]      size_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic                      dc_req_o,
    output logic [IDX_W-1:0]          dc_index_o,
    output logic [TAG_W-1:0]          dc_tag_o,
    output logic                      dc_tag_valid_o,
    output logic [7:0]                dc_be_o,
    output logic [1:0]                dc_size_o,
    output logic [2:0]                dc_id_o,
    output logic                      dc_kill_o,
    input  logic                      dc_gnt_i,
    input  logic                      dc_rvalid_i,
    input  logic [2:0]                dc_rid_i,
    input  logic [DATA_W-1:0]         dc_rdata_i,
    output logic                      timeout_o
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, REQ, TAG, RESP} state_e;

    state_e         state_q, state_d;
    logic [OW-1:0]  ptr_q, ptr_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic           drop_q, drop_d;
    logic [2:0]     resp_id;
    logic           rsp_match;
    logic           timeout_hit;

    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [OW-1:0] ptr);
        logic [OW-1:0] pick;
        logic          found;
        int            j;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = OW'(j);
            end
        end
        return pick;
    endfunction

    assign resp_id   = {1'b1, 2'(owner_q)};
    assign rsp_match = (state_q == RESP) && dc_rvalid_i && (dc_rid_i == resp_id);
    assign busy_o    = (state_q != IDLE);

`ifdef PTW_ARB_TIMEOUT_EN
    logic [9:0] cnt_q, cnt_d;
    assign timeout_hit = (state_q == RESP) && (cnt_q == 10'h3FF) && !rsp_match;
`else
    assign timeout_hit = 1'b0;
`endif
    assign timeout_o = timeout_hit;

    always_comb begin
        gnt_o          = '0;
        rvalid_o       = '0;
        rdata_o        = '0;
        dc_req_o       = 1'b0;
        dc_index_o     = '0;
        dc_be_o        = '0;
        dc_size_o      = '0;
        dc_tag_o       = '0;
        dc_tag_valid_o = 1'b0;
        dc_kill_o      = 1'b0;
        dc_id_o        = (state_q != IDLE) ? resp_id : 3'b000;
        case (state_q)
            REQ: begin
                // A withdrawn request must never be presented, so no grant can race the abandon.
                dc_req_o   = req_i[owner_q];
                dc_index_o = index_i[int'(owner_q)*IDX_W +: IDX_W];
                dc_be_o    = be_i[int'(owner_q)*8 +: 8];
                dc_size_o  = size_i[int'(owner_q)*2 +: 2];
                gnt_o[owner_q] = req_i[owner_q] && dc_gnt_i;
            end
            TAG: begin
                dc_tag_valid_o = 1'b1;
                dc_tag_o       = tag_i[int'(owner_q)*TAG_W +: TAG_W];
                dc_kill_o      = flush_i || drop_q;
            end
            RESP: begin
                if (rsp_match && !(drop_q || flush_i)) begin
                    rvalid_o[owner_q] = 1'b1;
                    rdata_o           = dc_rdata_i;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        drop_d  = drop_q;
`ifdef PTW_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    owner_d = rr_pick(req_i, ptr_q);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dc_req_o && dc_gnt_i) begin
                    state_d = TAG;
                    drop_d  = flush_i;
                    ptr_d   = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
                end else if (flush_i || !req_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            TAG: begin
                state_d = RESP;
                drop_d  = drop_q || flush_i;
`ifdef PTW_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            RESP: begin
                if (rsp_match || timeout_hit) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = drop_q || flush_i;
                end
`ifdef PTW_ARB_TIMEOUT_EN
                cnt_d   = cnt_q + 10'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            drop_q  <= 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
`ifdef PTW_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
